// File: rtl/alu_pkg.sv
// Shared constants for the lab CPU ALU: function codes, FSM encoding, loop sizing.
package alu_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SHL = 3'b101;
  localparam logic [2:0] ALU_MUL = 3'b110;
  localparam logic [2:0] ALU_DIV = 3'b111;

  // One iteration per operand bit; the 5-bit counter stops at ITER_LAST.
  localparam int         ITER_N    = 16;
  localparam int         CNT_W     = 5;
  localparam logic [4:0] ITER_LAST = 5'(ITER_N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } alu_state_e;

  function automatic logic is_iterative(input logic [2:0] func);
    return (func == ALU_MUL) || (func == ALU_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_core.sv
// Iterative datapath: shift/add multiply and restoring divide, one bit per step.
module alu_muldiv_core #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              last,
  output logic [DATA_W-1:0] res,
  output logic              res_c
);
  import alu_pkg::*;

  // MUL: acc = partial product, opa = shifted multiplicand, opb = multiplier.
  // DIV: acc[DATA_W:0] = remainder, opa[DATA_W-1:0] = dividend/quotient, opb = divisor.
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] opa;
  logic [DATA_W-1:0]   opb;
  logic [CNT_W-1:0]    cnt;
  logic                div_q;

  logic [2*DATA_W-1:0] mul_acc_nxt;
  logic [DATA_W:0]     rem_sh;
  logic [DATA_W+1:0]   trial;
  logic                borrow;
  logic [DATA_W:0]     rem_nxt;
  logic [DATA_W-1:0]   q_nxt;

  always_comb begin
    mul_acc_nxt = acc + (opb[0] ? opa : '0);
    rem_sh      = {acc[DATA_W-1:0], opa[DATA_W-1]};
    trial       = {1'b0, rem_sh} - {2'b00, opb};
    borrow      = trial[DATA_W+1];
    rem_nxt     = borrow ? rem_sh : trial[DATA_W:0];
    q_nxt       = {opa[DATA_W-2:0], ~borrow};
  end

  // Result of the step being taken this cycle, so the top can register it
  // on the same edge that performs the final iteration.
  assign res   = div_q ? q_nxt : mul_acc_nxt[DATA_W-1:0];
  assign res_c = div_q ? (opb == '0) : (|mul_acc_nxt[2*DATA_W-1:DATA_W]);
  assign last  = (cnt == ITER_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      opa   <= '0;
      opb   <= '0;
      cnt   <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      acc   <= '0;
      opa   <= {{DATA_W{1'b0}}, a};
      opb   <= b;
      cnt   <= '0;
      div_q <= is_div;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (div_q) begin
        acc <= {{(DATA_W-1){1'b0}}, rem_nxt};
        opa <= {{DATA_W{1'b0}}, q_nxt};
      end else begin
        acc <= mul_acc_nxt;
        opa <= opa << 1;
        opb <= opb >> 1;
      end
    end
  end

endmodule

// File: rtl/alu_unit.sv
// Lab CPU ALU: single-cycle logic/arith ops plus iterative MUL/DIV, registered result and flags.
//
// state  | meaning
// IDLE   | waiting for alu_start
// RUN    | MUL/DIV iterating, one bit per clock
// DONE   | result valid, alu_end high; a new alu_start is accepted here
module alu_unit #(
  parameter int DATA_W = alu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_start,
  input  logic [2:0]        alu_func,
  input  logic              alu_in_sel,
  input  logic [DATA_W-1:0] reg_a,
  input  logic [DATA_W-1:0] reg_b,
  input  logic [7:0]        ir_imm,
  output logic [DATA_W-1:0] alu_out,
  output logic              alu_end,
  output logic              alu_busy,
  output logic              flag_z,
  output logic              flag_c
);
  import alu_pkg::*;

  alu_state_e state;

  logic [DATA_W-1:0] op_b;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [DATA_W:0]   shl_wide;
  logic [DATA_W-1:0] sc_res;
  logic              sc_c;
  logic              accept;
  logic              iterative;
  logic              core_last;
  logic [DATA_W-1:0] core_res;
  logic              core_c;

  assign op_b      = alu_in_sel ? {{(DATA_W-8){1'b0}}, ir_imm} : reg_b;
  assign accept    = alu_start && ((state == S_IDLE) || (state == S_DONE));
  assign iterative = is_iterative(alu_func);

  always_comb begin
    sum      = {1'b0, reg_a} + {1'b0, op_b};
    diff     = {1'b0, reg_a} - {1'b0, op_b};
    // Bit DATA_W of the widened shift is the last bit pushed out (0 for count 0).
    shl_wide = {1'b0, reg_a} << op_b[3:0];
    sc_res   = '0;
    sc_c     = 1'b0;
    case (alu_func)
      ALU_ADD: begin sc_res = sum[DATA_W-1:0];      sc_c = sum[DATA_W];      end
      ALU_SUB: begin sc_res = diff[DATA_W-1:0];     sc_c = diff[DATA_W];     end
      ALU_AND: sc_res = reg_a & op_b;
      ALU_OR:  sc_res = reg_a | op_b;
      ALU_XOR: sc_res = reg_a ^ op_b;
      ALU_SHL: begin sc_res = shl_wide[DATA_W-1:0]; sc_c = shl_wide[DATA_W]; end
      default: begin sc_res = '0;                   sc_c = 1'b0;             end
    endcase
  end

  alu_muldiv_core #(.DATA_W(DATA_W)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (accept && iterative),
    .step   (state == S_RUN),
    .is_div (alu_func == ALU_DIV),
    .a      (reg_a),
    .b      (op_b),
    .last   (core_last),
    .res    (core_res),
    .res_c  (core_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      alu_out  <= '0;
      alu_end  <= 1'b0;
      alu_busy <= 1'b0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
    end else begin
      alu_end <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (iterative) begin
              state    <= S_RUN;
              alu_busy <= 1'b1;
            end else begin
              state   <= S_DONE;
              alu_out <= sc_res;
              flag_z  <= (sc_res == '0);
              flag_c  <= sc_c;
              alu_end <= 1'b1;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (core_last) begin
            state    <= S_DONE;
            alu_out  <= core_res;
            flag_z   <= (core_res == '0);
            flag_c   <= core_c;
            alu_end  <= 1'b1;
            alu_busy <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed cases plus randomized ops against an arithmetic model.
module tb_alu_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_start = 1'b0;
  logic [2:0]  alu_func = 3'b000;
  logic        alu_in_sel = 1'b0;
  logic [15:0] reg_a = 16'h0;
  logic [15:0] reg_b = 16'h0;
  logic [7:0]  ir_imm = 8'h0;
  logic [15:0] alu_out;
  logic        alu_end;
  logic        alu_busy;
  logic        flag_z;
  logic        flag_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_unit #(.DATA_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_start  (alu_start),
    .alu_func   (alu_func),
    .alu_in_sel (alu_in_sel),
    .reg_a      (reg_a),
    .reg_b      (reg_b),
    .ir_imm     (ir_imm),
    .alu_out    (alu_out),
    .alu_end    (alu_end),
    .alu_busy   (alu_busy),
    .flag_z     (flag_z),
    .flag_c     (flag_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {carry, result} from the arithmetic definition of each op.
  function automatic logic [16:0] model(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] t;
    logic [15:0] r;
    logic        c;
    t = 32'h0;
    r = 16'h0;
    c = 1'b0;
    case (f)
      3'd0: begin t = 32'(a) + 32'(b); r = t[15:0]; c = t[16]; end
      3'd1: begin r = a - b; c = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin t = 32'(a) << (b % 16); r = t[15:0]; c = t[16]; end
      3'd6: begin t = 32'(a) * 32'(b); r = t[15:0]; c = (t[31:16] != 16'h0); end
      default: begin
        if (b == 16'h0) begin r = 16'hFFFF; c = 1'b1; end
        else begin r = a / b; c = 1'b0; end
      end
    endcase
    return {c, r};
  endfunction

  task automatic drive_start(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                             input logic sel, input logic [7:0] imm);
    alu_func   = f;
    reg_a      = a;
    reg_b      = b;
    alu_in_sel = sel;
    ir_imm     = imm;
    alu_start  = 1'b1;
    @(posedge clk);
    #1;
    alu_start  = 1'b0;
    // Operands are latched at E0, so scramble them to prove it.
    reg_a      = 16'($urandom);
    reg_b      = 16'($urandom);
    ir_imm     = 8'($urandom);
    alu_func   = 3'($urandom);
    alu_in_sel = 1'($urandom);
  endtask

  task automatic do_op(input string tag, input logic [2:0] f, input logic [15:0] a,
                       input logic [15:0] b, input logic sel, input logic [7:0] imm);
    logic [15:0] eff_b;
    logic [16:0] exp;
    int          lat_exp;
    int          cyc;
    logic        busy_bad;
    eff_b   = sel ? {8'h00, imm} : b;
    exp     = model(f, a, eff_b);
    lat_exp = (f >= 3'd6) ? 17 : 1;
    drive_start(f, a, b, sel, imm);
    cyc      = 1;
    busy_bad = 1'b0;
    while (!alu_end && cyc < 40) begin
      if (alu_busy !== 1'b1) busy_bad = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(lat_exp));
    if (lat_exp == 1) check({tag, "_busy_low"}, 32'(alu_busy), 32'd0);
    else              check({tag, "_busy_run"}, 32'(busy_bad), 32'd0);
    check({tag, "_out"}, 32'(alu_out), 32'(exp[15:0]));
    check({tag, "_z"},   32'(flag_z),  32'(exp[15:0] == 16'h0));
    check({tag, "_c"},   32'(flag_c),  32'(exp[16]));
    @(posedge clk);
    #1;
    check({tag, "_end_pulse"}, 32'(alu_end), 32'd0);
  endtask

  initial begin
    int          n_end;
    int          first_end;
    logic [15:0] out_at_end;
    logic [2:0]  rf;
    logic [15:0] ra, rb;

    #23;
    check("reset_out",  32'(alu_out),  32'd0);
    check("reset_end",  32'(alu_end),  32'd0);
    check("reset_busy", 32'(alu_busy), 32'd0);
    check("reset_z",    32'(flag_z),   32'd0);
    check("reset_c",    32'(flag_c),   32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_op("add_wrap",  3'd0, 16'hFFFF, 16'h0001, 1'b0, 8'h00);
    do_op("sub_imm",   3'd1, 16'h0005, 16'h1234, 1'b1, 8'h07);
    do_op("shl_out",   3'd5, 16'h8001, 16'h0001, 1'b0, 8'h00);
    do_op("shl_zero",  3'd5, 16'h8001, 16'h0000, 1'b0, 8'h00);
    do_op("mul_small", 3'd6, 16'h0123, 16'h0010, 1'b0, 8'h00);
    do_op("mul_ovf",   3'd6, 16'h0100, 16'h0100, 1'b0, 8'h00);
    do_op("div_7",     3'd7, 16'd100,  16'd7,    1'b0, 8'h00);
    do_op("div_zero",  3'd7, 16'h1234, 16'h0000, 1'b0, 8'h00);
    do_op("mul_imm",   3'd6, 16'hFFFF, 16'h0000, 1'b1, 8'hFF);

    // Second alu_start during RUN must be dropped.
    drive_start(3'd6, 16'h0123, 16'h0010, 1'b0, 8'h00);
    n_end      = 0;
    first_end  = 0;
    out_at_end = 16'h0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 5) begin
        alu_func  = 3'd0;
        reg_a     = 16'h0001;
        reg_b     = 16'h0001;
        alu_start = 1'b1;
      end else begin
        alu_start = 1'b0;
      end
      if (alu_end) begin
        n_end++;
        if (n_end == 1) begin
          first_end  = i;
          out_at_end = alu_out;
        end
      end
      @(posedge clk);
      #1;
    end
    alu_start = 1'b0;
    check("run_ignore_count",   32'(n_end),      32'd1);
    check("run_ignore_latency", 32'(first_end),  32'd17);
    check("run_ignore_out",     32'(out_at_end), 32'h1230);

    // Back-to-back: a start in the DONE cycle is taken immediately.
    drive_start(3'd0, 16'h0001, 16'h0001, 1'b0, 8'h00);
    check("b2b_first_end", 32'(alu_end), 32'd1);
    check("b2b_first_out", 32'(alu_out), 32'h0002);
    drive_start(3'd4, 16'h00FF, 16'h0F0F, 1'b0, 8'h00);
    check("b2b_xor_end", 32'(alu_end), 32'd1);
    check("b2b_xor_out", 32'(alu_out), 32'h0FF0);
    check("b2b_xor_z",   32'(flag_z),  32'd0);
    check("b2b_xor_c",   32'(flag_c),  32'd0);
    @(posedge clk);
    #1;
    check("b2b_end_drop", 32'(alu_end), 32'd0);

    // Reset during DIV: set carry first so the reset clears something.
    do_op("pre_rst_add", 3'd0, 16'hFFFF, 16'h0003, 1'b0, 8'h00);
    drive_start(3'd7, 16'h1234, 16'h0003, 1'b0, 8'h00);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    check("rst_mid_busy_pre", 32'(alu_busy), 32'd1);
    rst = 1'b1;
    #2;
    check("rst_mid_out",  32'(alu_out),  32'd0);
    check("rst_mid_end",  32'(alu_end),  32'd0);
    check("rst_mid_busy", 32'(alu_busy), 32'd0);
    check("rst_mid_z",    32'(flag_z),   32'd0);
    check("rst_mid_c",    32'(flag_c),   32'd0);
    #2;
    rst = 1'b0;
    n_end = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (alu_end) n_end++;
    end
    check("rst_no_end", 32'(n_end), 32'd0);
    do_op("post_rst_add", 3'd0, 16'd2, 16'd3, 1'b0, 8'h00);

    for (int i = 0; i < 150; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 5))
        0: rb = 16'h0;
        1: ra = 16'hFFFF;
        2: rb = 16'($urandom_range(0, 15));
        default: ;
      endcase
      do_op($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb, 1'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
# alu_unit

Iterative 16-bit arithmetic/logic unit for the tiny lab CPU. It sits directly downstream of the control unit: it consumes `alu_func` and `alu_in_sel`, takes operands from the register group and the instruction immediate, and returns a registered result plus the one-cycle `alu_end` completion pulse that releases the control state machine from its execute state. Single-cycle ops finish in 1 cycle. MUL and DIV run a 16-step shift/add or shift/subtract loop.

## Interface
- `DATA_W`, default 16: datapath width. The CPU uses 16 only.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `alu_start` in 1: one-cycle request, driven on entry to the execute state.
- `alu_func` in 3: operation code, sampled with `alu_start`.
- `alu_in_sel` in 1: selects operand B. 0 = `reg_b`, 1 = zero-extended `ir_imm`.
- `reg_a` in 16: operand A (rd value).
- `reg_b` in 16: register operand B (rs value).
- `ir_imm` in 8: `ir_out[7:0]` immediate field.
- `alu_out` out 16: registered result. It holds until the next completion.
- `alu_end` out 1: one-cycle completion pulse.
- `alu_busy` out 1: high while an operation is in flight.
- `flag_z` out 1: result == 0. Updated with `alu_end`.
- `flag_c` out 1: carry/borrow/status. Updated with `alu_end`.

## Operation
- Function codes:
  - 000 ADD.
  - 001 SUB (A−B).
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SHL (A << B[3:0]).
  - 110 MUL (low 16 bits of the unsigned product).
  - 111 DIV (unsigned quotient A/B).
- States: IDLE, RUN, DONE.
- IDLE + `alu_start`:
  - Latch A, the selected B, and the function code.
  - Codes 000–101: compute and register the result, then go to DONE.
  - 110/111: load the iteration registers, clear the 5-bit counter, and go to RUN.
- RUN: one iteration per clock.
  - MUL is shift-add over B's bits.
  - DIV is restoring, one quotient bit per cycle.
  - On counter == 15, register the result and go to DONE.
- DONE: `alu_end`=1 for exactly this cycle.
  - No `alu_start` in this cycle: go to IDLE.
  - `alu_start` in this cycle: accept it exactly as in IDLE (back-to-back).
- `alu_start` while in RUN is ignored. It is not queued.
- `flag_c` per op:
  - ADD: carry out of bit 15.
  - SUB: borrow (A < B).
  - SHL: last bit shifted out, 0 when the shift count is 0.
  - MUL: 1 if product bits [31:16] are non-zero.
  - DIV: 1 if B == 0.
  - AND/OR/XOR: 0.
- Divide by zero: the restoring loop runs unchanged and yields quotient 0xFFFF. Latency is unchanged and `flag_c`=1.
- All arithmetic is unsigned and modulo 2^16. Immediates are zero-extended, never sign-extended.

## Timing
- Reset values: `alu_out`=0x0000, `alu_end`=0, `alu_busy`=0, `flag_z`=0, `flag_c`=0, state IDLE, counter 0.
- Notation: E0 is the edge that samples `alu_start`.
- Single-cycle ops: `alu_end`, `alu_out` and the flags are valid in the cycle after E0 (latency 1). `alu_busy` stays 0.
- MUL/DIV:
  - `alu_busy`=1 from E0 through E16.
  - `alu_end` is high in the cycle after E16 (latency 17).
- `alu_out` and the flags change only on the edge that enters DONE.
- `rst` mid-operation aborts the operation immediately.
  - No `alu_end` is produced for the aborted op.
  - All outputs return to their reset values.
- Operand inputs may change freely after E0; they are latched.

## Structure
- Package `alu_pkg` holds:
  - the `alu_func` code constants (ALU_ADD … ALU_DIV);
  - the state encoding (S_IDLE, S_RUN, S_DONE);
  - `DATA_W` and the iteration-count constant.
- The control unit's state machine imports the same function constants.
- Sub-module `alu_muldiv_core` contains the iterative MUL/DIV datapath:
  - accumulator/remainder, shifted operands, counter;
  - `load`/`step` inputs and a `last` output.
- `alu_unit` contains the FSM, the single-cycle ops and the flag logic.

## Test plan
- ADD 0xFFFF + 0x0001, `alu_in_sel`=0 → `alu_out`=0x0000, z=1, c=1. `alu_end` 1 cycle after start, `alu_busy` never high.
- SUB `reg_a`=0x0005, `alu_in_sel`=1, `ir_imm`=0x07 → 0xFFFE, z=0, c=1. SHL 0x8001 by 1 → 0x0002, c=1.
- MUL 0x0123 × 0x0010 → 0x1230, c=0, `alu_end` exactly 17 cycles after start. MUL 0x0100 × 0x0100 → 0x0000, z=1, c=1.
- DIV 100 / 7 → 0x000E, c=0. DIV 0x1234 / 0 → 0xFFFF, c=1, latency 17.
- Second `alu_start` during RUN is ignored: exactly one `alu_end` is produced. `alu_start` in the DONE cycle is accepted: XOR 0x00FF ^ 0x0F0F → 0x0FF0 one cycle later.
- `rst` pulsed during DIV iteration 8 → all outputs 0 and no `alu_end`. A following ADD 2+3 → 0x0005 with normal latency.
